// File: rtl/ixu_pkg.sv
// Shared IXU types: issue-queue entry layout and the issue word width that the
// multi-cycle pipe's data_i decode also relies on.
package ixu_pkg;

    localparam int IXU_ISSUE_W = 18;
    localparam int IXU_TAG_W   = 6;

    typedef struct packed {
        logic                 valid;
        logic [IXU_TAG_W-1:0] rob;
        logic [IXU_TAG_W-1:0] rs1;
        logic                 rs1_rdy;
        logic [IXU_TAG_W-1:0] rs2;
        logic                 rs2_rdy;
        logic                 is_div;
    } iq_entry_t;

endpackage

// File: rtl/ixu_iq_select.sv
// Lowest-index priority encoder shared by the IXU issue queues; slot 0 is the
// oldest entry, so the lowest set request is the oldest ready micro-op.
module ixu_iq_select #(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0]         req,
    output logic                     found,
    output logic [$clog2(DEPTH)-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = ($clog2(DEPTH))'(i);
            end
        end
    end

endmodule

// File: rtl/ixu_mc_issue_queue.sv
// Collapsing, age-ordered issue queue for the IXU multi-cycle pipe. Issues the
// oldest entry with both sources ready and holds off behind an in-flight divide.
module ixu_mc_issue_queue
    import ixu_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int NUM_WAKEUP = 3
) (
    input  logic                            core_clock_i,
    input  logic                            core_reset_i,
    input  logic                            core_flush_i,
    input  logic                            enq_valid_i,
    output logic                            enq_ready_o,
    input  logic [IXU_TAG_W-1:0]            enq_rob_i,
    input  logic [IXU_TAG_W-1:0]            enq_rs1_i,
    input  logic [IXU_TAG_W-1:0]            enq_rs2_i,
    input  logic                            enq_rs1_rdy_i,
    input  logic                            enq_rs2_rdy_i,
    input  logic                            enq_is_div_i,
    input  logic [IXU_TAG_W*NUM_WAKEUP-1:0] wakeup_dest_i,
    input  logic [NUM_WAKEUP-1:0]           wakeup_valid_i,
    output logic [IXU_ISSUE_W-1:0]          data_o,
    output logic                            valid_o,
    input  logic                            busy_i,
    output logic [$clog2(DEPTH):0]          occupancy_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    iq_entry_t        entries     [DEPTH];
    iq_entry_t        woken       [DEPTH];
    iq_entry_t        entries_nxt [DEPTH];
    iq_entry_t        enq_entry;
    logic [CNT_W-1:0] occupancy;
    logic [CNT_W-1:0] ins_idx;
    logic             div_inflight;
    logic [DEPTH-1:0] issue_req;
    logic             found;
    logic [IDX_W-1:0] sel_idx;
    logic             issue_fire;
    logic             enq_fire;

    // Tag 0 is x0 and never broadcast as a real producer, so it is ignored here.
    function automatic logic tag_woken(input logic [IXU_TAG_W-1:0]            tag,
                                       input logic [IXU_TAG_W*NUM_WAKEUP-1:0] dest,
                                       input logic [NUM_WAKEUP-1:0]           vld);
        logic hit;
        hit = 1'b0;
        for (int b = 0; b < NUM_WAKEUP; b++) begin
            if (vld[b] && dest[b*IXU_TAG_W +: IXU_TAG_W] != '0 &&
                dest[b*IXU_TAG_W +: IXU_TAG_W] == tag) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            issue_req[i] = entries[i].valid & entries[i].rs1_rdy & entries[i].rs2_rdy;
        end
    end

    ixu_iq_select #(.DEPTH(DEPTH)) u_select (
        .req   (issue_req),
        .found (found),
        .idx   (sel_idx)
    );

    // Select sees only registered ready bits, so a same-cycle wakeup waits a cycle.
    assign valid_o     = found & (~div_inflight | ~busy_i);
    assign issue_fire  = valid_o;
    assign data_o      = {entries[sel_idx].rs2, entries[sel_idx].rs1, entries[sel_idx].rob};
    assign enq_ready_o = occupancy < CNT_W'(DEPTH);
    assign enq_fire    = enq_valid_i & enq_ready_o;
    assign ins_idx     = occupancy - CNT_W'(issue_fire);
    assign occupancy_o = occupancy;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = entries[i];
            if (entries[i].valid) begin
                if (tag_woken(entries[i].rs1, wakeup_dest_i, wakeup_valid_i)) woken[i].rs1_rdy = 1'b1;
                if (tag_woken(entries[i].rs2, wakeup_dest_i, wakeup_valid_i)) woken[i].rs2_rdy = 1'b1;
            end
        end

        enq_entry.valid   = 1'b1;
        enq_entry.rob     = enq_rob_i;
        enq_entry.rs1     = enq_rs1_i;
        enq_entry.rs2     = enq_rs2_i;
        enq_entry.is_div  = enq_is_div_i;
        enq_entry.rs1_rdy = enq_rs1_rdy_i | (enq_rs1_i == '0) |
                            tag_woken(enq_rs1_i, wakeup_dest_i, wakeup_valid_i);
        enq_entry.rs2_rdy = enq_rs2_rdy_i | (enq_rs2_i == '0) |
                            tag_woken(enq_rs2_i, wakeup_dest_i, wakeup_valid_i);

        // Wakeup is applied before the collapse, so it follows entries by value.
        for (int i = 0; i < DEPTH - 1; i++) begin
            entries_nxt[i] = (issue_fire && IDX_W'(i) >= sel_idx) ? woken[i+1] : woken[i];
        end
        entries_nxt[DEPTH-1] = issue_fire ? '0 : woken[DEPTH-1];

        if (enq_fire) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == ins_idx) entries_nxt[i] = enq_entry;
            end
        end
    end

    always_ff @(posedge core_clock_i) begin
        if (core_reset_i || core_flush_i) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
            occupancy    <= '0;
            div_inflight <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= entries_nxt[i];
            occupancy <= occupancy + CNT_W'(enq_fire) - CNT_W'(issue_fire);
            // A divide issued in the divider-done cycle must re-arm the gate.
            if (issue_fire && entries[sel_idx].is_div) begin
                div_inflight <= 1'b1;
            end else if (div_inflight && !busy_i) begin
                div_inflight <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ixu_mc_issue_queue.sv
// Scoreboarded bench for ixu_mc_issue_queue: expected issue words are queued as
// stimulus is driven and matched against words captured whenever valid_o is high.
module tb_ixu_mc_issue_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        enq_valid;
    logic        enq_ready;
    logic [5:0]  enq_rob;
    logic [5:0]  enq_rs1;
    logic [5:0]  enq_rs2;
    logic        enq_rs1_rdy;
    logic        enq_rs2_rdy;
    logic        enq_is_div;
    logic [17:0] wakeup_dest;
    logic [2:0]  wakeup_valid;
    logic [17:0] data;
    logic        valid;
    logic        busy;
    logic [3:0]  occupancy;

    int          checks;
    int          errors;
    logic [17:0] exp_q[$];
    logic [17:0] obs_q[$];
    logic [17:0] got;
    logic [17:0] want;

    ixu_mc_issue_queue #(.DEPTH(8), .NUM_WAKEUP(3)) dut (
        .core_clock_i   (clk),
        .core_reset_i   (rst),
        .core_flush_i   (flush),
        .enq_valid_i    (enq_valid),
        .enq_ready_o    (enq_ready),
        .enq_rob_i      (enq_rob),
        .enq_rs1_i      (enq_rs1),
        .enq_rs2_i      (enq_rs2),
        .enq_rs1_rdy_i  (enq_rs1_rdy),
        .enq_rs2_rdy_i  (enq_rs2_rdy),
        .enq_is_div_i   (enq_is_div),
        .wakeup_dest_i  (wakeup_dest),
        .wakeup_valid_i (wakeup_valid),
        .data_o         (data),
        .valid_o        (valid),
        .busy_i         (busy),
        .occupancy_o    (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every issued word at the falling edge, away from input changes.
    always @(negedge clk) begin
        if (!rst && valid === 1'b1) obs_q.push_back(data);
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_enq(input logic [5:0] rob, input logic [5:0] rs1, input logic r1,
                             input logic [5:0] rs2, input logic r2, input logic dv);
        enq_valid   = 1'b1;
        enq_rob     = rob;
        enq_rs1     = rs1;
        enq_rs1_rdy = r1;
        enq_rs2     = rs2;
        enq_rs2_rdy = r2;
        enq_is_div  = dv;
    endtask

    task automatic set_wakeup(input int bus, input logic [5:0] tag);
        wakeup_dest[bus*6 +: 6] = tag;
        wakeup_valid[bus]       = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", valid); end
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_enq_ready got %b want 1", enq_ready); end
        checks++; if (data !== 18'h0) begin errors++; $display("[TB] FAIL reset_data got %h want 0", data); end
        checks++; if (occupancy !== 4'd0) begin errors++; $display("[TB] FAIL reset_occ got %0d want 0", occupancy); end
        next_cycle();
    endtask

    task automatic test_basic();
        // rs1/rs2 = x0 are offered as not-ready; the queue must treat them as ready.
        drive_enq(6'd3, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_same_cycle got %b want 0", valid); end
        next_cycle();
        enq_valid = 1'b0;
        exp_q.push_back(18'h00003);
        @(negedge clk);
        checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid got %b want 1", valid); end
        checks++; if (data !== 18'h00003) begin errors++; $display("[TB] FAIL basic_data got %h want 00003", data); end
        checks++; if (occupancy !== 4'd1) begin errors++; $display("[TB] FAIL basic_occ1 got %0d want 1", occupancy); end
        next_cycle();
        @(negedge clk);
        checks++; if (occupancy !== 4'd0) begin errors++; $display("[TB] FAIL basic_occ0 got %0d want 0", occupancy); end
        next_cycle();
        while (exp_q.size() > 0) begin
            checks++; want = exp_q.pop_front();
            if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL basic_sb got none want %h", want); end
            else begin got = obs_q.pop_front(); if (got !== want) begin errors++; $display("[TB] FAIL basic_sb got %h want %h", got, want); end end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL basic_extra got %0d want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_order();
        drive_enq(6'd1, 6'd5, 1'b0, 6'd0, 1'b0, 1'b0);
        next_cycle();
        drive_enq(6'd2, 6'd6, 1'b1, 6'd7, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL order_a_blocked got %b want 0", valid); end
        next_cycle();
        enq_valid = 1'b0;
        exp_q.push_back({6'd7, 6'd6, 6'd2});
        @(negedge clk);
        checks++; if (valid !== 1'b1 || data !== {6'd7, 6'd6, 6'd2}) begin errors++; $display("[TB] FAIL order_b_first got %b/%h want 1/%h", valid, data, {6'd7, 6'd6, 6'd2}); end
        next_cycle();
        set_wakeup(1, 6'd5);
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL order_wake_same_cycle got %b want 0", valid); end
        checks++; if (occupancy !== 4'd1) begin errors++; $display("[TB] FAIL order_occ got %0d want 1", occupancy); end
        next_cycle();
        wakeup_valid = 3'b000;
        exp_q.push_back({6'd0, 6'd5, 6'd1});
        @(negedge clk);
        checks++; if (valid !== 1'b1 || data !== {6'd0, 6'd5, 6'd1}) begin errors++; $display("[TB] FAIL order_a_woken got %b/%h want 1/%h", valid, data, {6'd0, 6'd5, 6'd1}); end
        next_cycle();
        while (exp_q.size() > 0) begin
            checks++; want = exp_q.pop_front();
            if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL order_sb got none want %h", want); end
            else begin got = obs_q.pop_front(); if (got !== want) begin errors++; $display("[TB] FAIL order_sb got %h want %h", got, want); end end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL order_extra got %0d want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_div_busy();
        drive_enq(6'd4, 6'd10, 1'b1, 6'd11, 1'b1, 1'b1);
        next_cycle();
        drive_enq(6'd5, 6'd12, 1'b1, 6'd13, 1'b1, 1'b0);
        exp_q.push_back({6'd11, 6'd10, 6'd4});
        @(negedge clk);
        checks++; if (valid !== 1'b1 || data !== {6'd11, 6'd10, 6'd4}) begin errors++; $display("[TB] FAIL div_issue got %b/%h want 1/%h", valid, data, {6'd11, 6'd10, 6'd4}); end
        next_cycle();
        enq_valid = 1'b0;
        busy      = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL div_withheld_%0d got %b want 0", k, valid); end
            next_cycle();
        end
        busy = 1'b0;
        exp_q.push_back({6'd13, 6'd12, 6'd5});
        @(negedge clk);
        checks++; if (valid !== 1'b1 || data !== {6'd13, 6'd12, 6'd5}) begin errors++; $display("[TB] FAIL div_done_issue got %b/%h want 1/%h", valid, data, {6'd13, 6'd12, 6'd5}); end
        next_cycle();
        busy = 1'b1;
        drive_enq(6'd6, 6'd14, 1'b1, 6'd15, 1'b1, 1'b0);
        next_cycle();
        enq_valid = 1'b0;
        exp_q.push_back({6'd15, 6'd14, 6'd6});
        @(negedge clk);
        checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL div_cleared_ignores_busy got %b want 1", valid); end
        next_cycle();
        busy = 1'b0;
        while (exp_q.size() > 0) begin
            checks++; want = exp_q.pop_front();
            if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL div_sb got none want %h", want); end
            else begin got = obs_q.pop_front(); if (got !== want) begin errors++; $display("[TB] FAIL div_sb got %h want %h", got, want); end end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL div_extra got %0d want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_full_collapse();
        int n;
        for (int i = 0; i < 8; i++) begin
            drive_enq(6'(8 + i), 6'(20 + i), 1'b0, 6'd0, 1'b0, 1'b0);
            next_cycle();
        end
        enq_valid = 1'b0;
        @(negedge clk);
        checks++; if (occupancy !== 4'd8) begin errors++; $display("[TB] FAIL full_occ got %0d want 8", occupancy); end
        checks++; if (enq_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready got %b want 0", enq_ready); end
        next_cycle();
        set_wakeup(0, 6'd23);
        drive_enq(6'd16, 6'd30, 1'b0, 6'd0, 1'b0, 1'b0);
        next_cycle();
        wakeup_valid = 3'b000;
        exp_q.push_back({6'd0, 6'd23, 6'd11});
        @(negedge clk);
        checks++; if (valid !== 1'b1 || data !== {6'd0, 6'd23, 6'd11}) begin errors++; $display("[TB] FAIL full_slot3 got %b/%h want 1/%h", valid, data, {6'd0, 6'd23, 6'd11}); end
        checks++; if (enq_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_no_credit got %b want 0", enq_ready); end
        next_cycle();
        @(negedge clk);
        checks++; if (enq_ready !== 1'b1 || occupancy !== 4'd7) begin errors++; $display("[TB] FAIL full_reopen got %b/%0d want 1/7", enq_ready, occupancy); end
        next_cycle();
        enq_valid = 1'b0;
        set_wakeup(0, 6'd20); set_wakeup(1, 6'd21); set_wakeup(2, 6'd22);
        @(negedge clk);
        checks++; if (occupancy !== 4'd8) begin errors++; $display("[TB] FAIL full_refill got %0d want 8", occupancy); end
        next_cycle();
        set_wakeup(0, 6'd24); set_wakeup(1, 6'd25); set_wakeup(2, 6'd26);
        next_cycle();
        wakeup_valid = 3'b000;
        set_wakeup(0, 6'd27); set_wakeup(1, 6'd30);
        next_cycle();
        wakeup_valid = 3'b000;
        for (int i = 0; i < 8; i++) begin
            if (i != 3) exp_q.push_back({6'd0, 6'(20 + i), 6'(8 + i)});
        end
        exp_q.push_back({6'd0, 6'd30, 6'd16});
        n = 0;
        @(negedge clk);
        while (occupancy !== 4'd0 && n < 20) begin
            next_cycle();
            @(negedge clk);
            n++;
        end
        checks++; if (occupancy !== 4'd0) begin errors++; $display("[TB] FAIL full_drain got %0d want 0", occupancy); end
        next_cycle();
        while (exp_q.size() > 0) begin
            checks++; want = exp_q.pop_front();
            if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL full_sb got none want %h", want); end
            else begin got = obs_q.pop_front(); if (got !== want) begin errors++; $display("[TB] FAIL full_sb got %h want %h", got, want); end end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL full_extra got %0d want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_enq_bypass();
        drive_enq(6'd20, 6'd9, 1'b0, 6'd0, 1'b0, 1'b0);
        set_wakeup(2, 6'd9);
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL bypass_same_cycle got %b want 0", valid); end
        next_cycle();
        enq_valid    = 1'b0;
        wakeup_valid = 3'b000;
        exp_q.push_back({6'd0, 6'd9, 6'd20});
        @(negedge clk);
        checks++; if (valid !== 1'b1 || data !== {6'd0, 6'd9, 6'd20}) begin errors++; $display("[TB] FAIL bypass_issue got %b/%h want 1/%h", valid, data, {6'd0, 6'd9, 6'd20}); end
        next_cycle();
        while (exp_q.size() > 0) begin
            checks++; want = exp_q.pop_front();
            if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL bypass_sb got none want %h", want); end
            else begin got = obs_q.pop_front(); if (got !== want) begin errors++; $display("[TB] FAIL bypass_sb got %h want %h", got, want); end end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL bypass_extra got %0d want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_flush();
        drive_enq(6'd30, 6'd1, 1'b1, 6'd2, 1'b1, 1'b1);
        next_cycle();
        enq_valid = 1'b0;
        exp_q.push_back({6'd2, 6'd1, 6'd30});
        @(negedge clk);
        checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL flush_div_issue got %b want 1", valid); end
        next_cycle();
        busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive_enq(6'(40 + k), 6'(40 + k), 1'b0, 6'd0, 1'b0, 1'b0);
            next_cycle();
        end
        flush = 1'b1;
        drive_enq(6'd36, 6'd3, 1'b1, 6'd4, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (occupancy !== 4'd5) begin errors++; $display("[TB] FAIL flush_pre_occ got %0d want 5", occupancy); end
        next_cycle();
        flush     = 1'b0;
        enq_valid = 1'b0;
        @(negedge clk);
        checks++; if (occupancy !== 4'd0) begin errors++; $display("[TB] FAIL flush_occ got %0d want 0", occupancy); end
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid got %b want 0", valid); end
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_ready got %b want 1", enq_ready); end
        checks++; if (data !== 18'h0) begin errors++; $display("[TB] FAIL flush_data got %h want 0", data); end
        next_cycle();
        drive_enq(6'd35, 6'd3, 1'b1, 6'd4, 1'b1, 1'b0);
        next_cycle();
        enq_valid = 1'b0;
        exp_q.push_back({6'd4, 6'd3, 6'd35});
        @(negedge clk);
        checks++; if (valid !== 1'b1 || data !== {6'd4, 6'd3, 6'd35}) begin errors++; $display("[TB] FAIL flush_post_issue got %b/%h want 1/%h", valid, data, {6'd4, 6'd3, 6'd35}); end
        next_cycle();
        busy = 1'b0;
        next_cycle();
        while (exp_q.size() > 0) begin
            checks++; want = exp_q.pop_front();
            if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL flush_sb got none want %h", want); end
            else begin got = obs_q.pop_front(); if (got !== want) begin errors++; $display("[TB] FAIL flush_sb got %h want %h", got, want); end end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL flush_extra got %0d want 0", obs_q.size()); obs_q.delete(); end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        flush        = 1'b0;
        busy         = 1'b0;
        enq_valid    = 1'b0;
        enq_rob      = '0;
        enq_rs1      = '0;
        enq_rs2      = '0;
        enq_rs1_rdy  = 1'b0;
        enq_rs2_rdy  = 1'b0;
        enq_is_div   = 1'b0;
        wakeup_dest  = '0;
        wakeup_valid = '0;
        $display("[TB] starting ixu_mc_issue_queue bench");
        test_reset();
        test_basic();
        test_order();
        test_div_busy();
        test_full_collapse();
        test_enq_bypass();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
